// File: rtl/csa8_selfcheck.sv
// Self-checking carry-select adder harness: on-chip stimulus (counter or LFSR),
// carry-select adder under test, behavioural reference and mismatch/vector counters.
module csa8_selfcheck #(
    parameter int          N           = 8,
    parameter int          BLOCK       = 4,
    parameter int          NUM_VECTORS = 30000,
    parameter logic [31:0] SEED        = 32'hACE1_0001
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         mode,
    input  logic         fault_inject,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic [N-1:0] s_ref,
    output logic         cout_ref,
    output logic         prop,
    output logic         gen,
    output logic         mismatch,
    output logic [15:0]  err_count,
    output logic [31:0]  vec_count,
    output logic         done
);
    localparam int VW = 2 * N + 1;
    localparam int NW = (VW + 31) / 32;
    localparam int NB = N / BLOCK;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    // Successive LFSR states packed lowest word first, so wide operands get fresh bits.
    function automatic logic [NW*32-1:0] lfsr_fill(input logic [31:0] start);
        logic [NW*32-1:0] f;
        logic [31:0]      st;
        f  = '0;
        st = start;
        for (int i = 0; i < NW; i++) begin
            f[i*32 +: 32] = st;
            st            = lfsr_step(st);
        end
        return f;
    endfunction

    function automatic logic [BLOCK:0] ripple(input logic [BLOCK-1:0] x,
                                              input logic [BLOCK-1:0] y,
                                              input logic             ci);
        logic [BLOCK:0] r;
        logic           c;
        r = '0;
        c = ci;
        for (int i = 0; i < BLOCK; i++) begin
            r[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        r[BLOCK] = c;
        return r;
    endfunction

    localparam logic [NW*32-1:0] SEED_FILL = lfsr_fill(SEED);

    logic [VW-1:0]    vec;
    logic [31:0]      lfsr_q;
    logic             mode_q;
    logic [NW*32-1:0] next_fill;
    logic [NB:0]      carry;
    logic [N-1:0]     csa_sum;
    logic             active;
    logic             cmp;

    assign cin       = vec[2*N];
    assign a         = vec[2*N-1:N];
    assign b         = vec[N-1:0];
    assign next_fill = lfsr_fill(lfsr_step(lfsr_q));
    assign carry[0]  = cin;

    // Block 0 ripples from cin; later blocks precompute both carry-in cases and select.
    for (genvar g = 0; g < NB; g++) begin : blk
        logic [BLOCK:0] sel;
        if (g == 0) begin : rca
            assign sel = ripple(a[g*BLOCK +: BLOCK], b[g*BLOCK +: BLOCK], carry[g]);
        end else begin : csel
            logic [BLOCK:0] r0;
            logic [BLOCK:0] r1;
            assign r0  = ripple(a[g*BLOCK +: BLOCK], b[g*BLOCK +: BLOCK], 1'b0);
            assign r1  = ripple(a[g*BLOCK +: BLOCK], b[g*BLOCK +: BLOCK], 1'b1);
            assign sel = carry[g] ? r1 : r0;
        end
        assign csa_sum[g*BLOCK +: BLOCK] = sel[BLOCK-1:0];
        assign carry[g+1]                = sel[BLOCK];
    end

    assign s                 = csa_sum ^ N'(fault_inject);
    assign cout              = carry[NB];
    assign {cout_ref, s_ref} = (N+1)'(a) + (N+1)'(b) + (N+1)'(cin);
    assign prop              = &(a ^ b);
    assign gen               = (a > ~b);
    assign cmp               = ({cout, s} != {cout_ref, s_ref});
    assign active            = enable && !done;

    // Mode is latched only during reset, which also picks the initial stimulus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= mode;
            lfsr_q    <= SEED_FILL[NW*32-1 -: 32];
            vec       <= mode ? SEED_FILL[VW-1:0] : '0;
            mismatch  <= 1'b0;
            err_count <= '0;
            vec_count <= '0;
            done      <= 1'b0;
        end else if (active) begin
            mismatch <= cmp;
            if (cmp && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
            vec_count <= vec_count + 32'd1;
            if (vec_count + 32'd1 == 32'(NUM_VECTORS))
                done <= 1'b1;
            if (mode_q) begin
                vec    <= next_fill[VW-1:0];
                lfsr_q <= next_fill[NW*32-1 -: 32];
            end else begin
                vec <= vec + VW'(1);
            end
        end else begin
            mismatch <= 1'b0;
        end
    end
endmodule

// File: tb/tb_csa8_selfcheck.sv
// Randomised bench for csa8_selfcheck: an 8-bit instance for LFSR/fault/reset behaviour
// and a 4-bit instance small enough to sweep its whole counter space and reach done.
module tb_csa8_selfcheck;
    localparam logic [31:0] SEED = 32'hACE1_0001;
    localparam int          NV8  = 3000;
    localparam int          NV4  = 520;

    logic clk = 1'b0;
    logic rst, en8, mode8, fi8, en4, mode4, fi4;

    logic [7:0]  a8, b8, s8, sr8;
    logic        cin8, cout8, cr8, prop8, gen8, mis8, done8;
    logic [15:0] err8;
    logic [31:0] vc8;
    logic [3:0]  a4, b4, s4, sr4;
    logic        cin4, cout4, cr4, prop4, gen4, mis4, done4;
    logic [15:0] err4;
    logic [31:0] vc4;

    csa8_selfcheck #(.N(8), .BLOCK(4), .NUM_VECTORS(NV8), .SEED(SEED)) dut8 (
        .clk(clk), .rst(rst), .enable(en8), .mode(mode8), .fault_inject(fi8),
        .a(a8), .b(b8), .cin(cin8), .s(s8), .cout(cout8), .s_ref(sr8), .cout_ref(cr8),
        .prop(prop8), .gen(gen8), .mismatch(mis8), .err_count(err8),
        .vec_count(vc8), .done(done8));

    csa8_selfcheck #(.N(4), .BLOCK(2), .NUM_VECTORS(NV4), .SEED(SEED)) dut4 (
        .clk(clk), .rst(rst), .enable(en4), .mode(mode4), .fault_inject(fi4),
        .a(a4), .b(b4), .cin(cin4), .s(s4), .cout(cout4), .s_ref(sr4), .cout_ref(cr4),
        .prop(prop4), .gen(gen4), .mismatch(mis4), .err_count(err4),
        .vec_count(vc4), .done(done4));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [36:0] obs8;
    logic [49:0] st8;
    logic [20:0] obs4;
    logic [49:0] st4;
    assign obs8 = {a8, b8, cin8, s8, cout8, sr8, cr8, prop8, gen8};
    assign st8  = {mis8, err8, vc8, done8};
    assign obs4 = {a4, b4, cin4, s4, cout4, sr4, cr4, prop4, gen4};
    assign st4  = {mis4, err4, vc4, done4};

    // Reference model: stimulus as a plain {cin,a,b} number, results from integer arithmetic.
    logic [16:0] v8;
    logic [31:0] l8;
    bit          md8, mis8m, done8m;
    int          err8m, vec8m;
    logic [8:0]  v4;
    bit          mis4m, done4m;
    int          err4m, vec4m;

    function automatic logic [31:0] lstep(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    function automatic logic [36:0] exp_comb8();
        int av, bv, cv, sum;
        av  = int'(v8[15:8]);
        bv  = int'(v8[7:0]);
        cv  = int'(v8[16]);
        sum = av + bv + cv;
        return {8'(av), 8'(bv), 1'(cv), 8'(sum % 256) ^ {7'b0, fi8}, 1'(sum / 256),
                8'(sum % 256), 1'(sum / 256), 1'((av ^ bv) == 255), 1'(av + bv > 255)};
    endfunction

    function automatic logic [20:0] exp_comb4();
        int av, bv, cv, sum;
        av  = int'(v4[7:4]);
        bv  = int'(v4[3:0]);
        cv  = int'(v4[8]);
        sum = av + bv + cv;
        return {4'(av), 4'(bv), 1'(cv), 4'(sum % 16) ^ {3'b0, fi4}, 1'(sum / 16),
                4'(sum % 16), 1'(sum / 16), 1'((av ^ bv) == 15), 1'(av + bv > 15)};
    endfunction

    function automatic logic [49:0] exp_st8();
        return {mis8m, 16'(err8m), 32'(vec8m), done8m};
    endfunction

    function automatic logic [49:0] exp_st4();
        return {mis4m, 16'(err4m), 32'(vec4m), done4m};
    endfunction

    task automatic model_reset();
        md8    = mode8;
        l8     = SEED;
        v8     = mode8 ? SEED[16:0] : 17'd0;
        mis8m  = 0; done8m = 0; err8m = 0; vec8m = 0;
        v4     = 9'd0;
        mis4m  = 0; done4m = 0; err4m = 0; vec4m = 0;
    endtask

    task automatic model_edge();
        if (en8 && !done8m) begin
            mis8m = fi8;
            if (fi8 && err8m < 65535) err8m++;
            vec8m++;
            if (vec8m == NV8) done8m = 1;
            if (md8) begin
                l8 = lstep(l8);
                v8 = l8[16:0];
            end else begin
                v8 = v8 + 17'd1;
            end
        end else begin
            mis8m = 0;
        end
        if (en4 && !done4m) begin
            mis4m = fi4;
            if (fi4 && err4m < 65535) err4m++;
            vec4m++;
            if (vec4m == NV4) done4m = 1;
            v4 = v4 + 9'd1;
        end else begin
            mis4m = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset(input bit m8);
        @(negedge clk);
        mode8 = m8;
        mode4 = 1'b0;
        rst   = 1'b1;
        #1 model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en8 = 0; en4 = 0; fi8 = 0; fi4 = 0;
        do_reset(1'b0);
        checks++;
        if ({a8, b8, cin8, s8, cout8, prop8, gen8} !== 28'd0) begin
            failures++;
            $display("[TB] FAIL reset_operands got=%h exp=0", {a8, b8, cin8, s8, cout8, prop8, gen8});
        end
        checks++;
        if (obs8 !== exp_comb8()) begin
            failures++;
            $display("[TB] FAIL reset_comb8 got=%h exp=%h", obs8, exp_comb8());
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (st8 !== 50'd0) begin
                failures++;
                $display("[TB] FAIL idle_state8 got=%h exp=0", st8);
            end
            checks++;
            if (st4 !== 50'd0) begin
                failures++;
                $display("[TB] FAIL idle_state4 got=%h exp=0", st4);
            end
        end
    endtask

    task automatic test_counter_sweep();
        int done_at = -1;
        int hit_ff  = 0;
        int hit_sel = 0;
        en4 = 1;
        for (int i = 0; i < NV4 + 8; i++) begin
            en8 = 1'($urandom_range(0, 1));
            tick();
            if (done4 && done_at < 0) done_at = i + 1;
            checks++;
            if (obs4 !== exp_comb4()) begin
                failures++;
                $display("[TB] FAIL sweep_comb4 got=%h exp=%h", obs4, exp_comb4());
            end
            checks++;
            if (st4 !== exp_st4()) begin
                failures++;
                $display("[TB] FAIL sweep_state4 got=%h exp=%h", st4, exp_st4());
            end
            checks++;
            if (obs8 !== exp_comb8() || st8 !== exp_st8()) begin
                failures++;
                $display("[TB] FAIL counter8 got=%h/%h exp=%h/%h", obs8, st8, exp_comb8(), exp_st8());
            end
            if (a4 == 4'hF && b4 == 4'h1 && !cin4) begin
                hit_ff++;
                checks++;
                if ({s4, cout4, prop4, gen4} !== 7'b0000_1_0_1) begin
                    failures++;
                    $display("[TB] FAIL carry_out_vec got=%b exp=0000101", {s4, cout4, prop4, gen4});
                end
            end
            if (a4 == 4'h3 && b4 == 4'hC && cin4) begin
                hit_sel++;
                checks++;
                if ({s4, cout4, prop4, gen4} !== 7'b0000_1_1_0) begin
                    failures++;
                    $display("[TB] FAIL propagate_vec got=%b exp=0000110", {s4, cout4, prop4, gen4});
                end
            end
        end
        checks++;
        if (done_at !== NV4) begin
            failures++;
            $display("[TB] FAIL done_cycle got=%0d exp=%0d", done_at, NV4);
        end
        checks++;
        if (hit_ff !== 1 || hit_sel !== 1) begin
            failures++;
            $display("[TB] FAIL vector_coverage got=%0d,%0d exp=1,1", hit_ff, hit_sel);
        end
        checks++;
        if ({cin4, a4, b4, err4, vc4} !== {9'd8, 16'd0, 32'(NV4)}) begin
            failures++;
            $display("[TB] FAIL hold_after_done got=%h exp=%h", {cin4, a4, b4, err4, vc4}, {9'd8, 16'd0, 32'(NV4)});
        end
        en4 = 0;
    endtask

    task automatic test_fault();
        int e0;
        e0  = err8m;
        en8 = 1;
        fi8 = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (mis8 !== 1'b1 || st8 !== exp_st8()) begin
                failures++;
                $display("[TB] FAIL fault_edge got=%h exp=%h", st8, exp_st8());
            end
        end
        checks++;
        if (obs8 !== exp_comb8()) begin
            failures++;
            $display("[TB] FAIL fault_sum got=%h exp=%h", obs8, exp_comb8());
        end
        en8 = 0;
        tick();
        checks++;
        if (mis8 !== 1'b0 || err8 !== 16'(e0 + 5)) begin
            failures++;
            $display("[TB] FAIL fault_disabled got=%b,%0d exp=0,%0d", mis8, err8, e0 + 5);
        end
        en8 = 1;
        fi8 = 0;
        tick();
        checks++;
        if (st8 !== exp_st8() || err8 !== 16'(e0 + 5)) begin
            failures++;
            $display("[TB] FAIL fault_cleared got=%h exp=%h", st8, exp_st8());
        end
    endtask

    task automatic run_lfsr(input int n);
        for (int i = 0; i < n; i++) begin
            en8 = ($urandom_range(0, 3) != 0);
            fi8 = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if (obs8 !== exp_comb8()) begin
                failures++;
                $display("[TB] FAIL lfsr_comb8 got=%h exp=%h", obs8, exp_comb8());
            end
            checks++;
            if (st8 !== exp_st8()) begin
                failures++;
                $display("[TB] FAIL lfsr_state8 got=%h exp=%h", st8, exp_st8());
            end
        end
    endtask

    task automatic test_lfsr_restart();
        en8 = 0; fi8 = 0; en4 = 0;
        do_reset(1'b1);
        checks++;
        if ({cin8, a8, b8} !== SEED[16:0]) begin
            failures++;
            $display("[TB] FAIL lfsr_seed got=%h exp=%h", {cin8, a8, b8}, SEED[16:0]);
        end
        mode8 = 0;
        run_lfsr(1000);
        fi8 = 0;
        mode8 = 1;
        @(posedge clk);
        model_edge();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({st8, cin8, a8, b8} !== {50'd0, SEED[16:0]}) begin
            failures++;
            $display("[TB] FAIL async_reset got=%h exp=%h", {st8, cin8, a8, b8}, {50'd0, SEED[16:0]});
        end
        model_reset();
        @(negedge clk);
        rst   = 1'b0;
        mode8 = 0;
        run_lfsr(200);
    endtask

    initial begin
        rst = 1; en8 = 0; en4 = 0; fi8 = 0; fi4 = 0; mode8 = 0; mode4 = 0;
        test_reset();
        test_counter_sweep();
        test_fault();
        test_lfsr_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/csa8_selfcheck.md
# csa8_selfcheck

Self-checking carry-select adder unit. A parameterised carry-select adder (default 8 bits) is driven by an on-chip stimulus generator (exhaustive counter or LFSR) and compared every cycle against a behavioural reference sum. Mismatches and applied vectors are counted. The block serves as the adder-verification and switching-activity harness in the adder characterisation flow.

## Interface
Parameters:
- `N`, 8: operand width.
- `BLOCK`, 4: carry-select block width. Must divide `N`.
- `NUM_VECTORS`, 30000: number of vectors to apply before `done`.
- `SEED`, 32'hACE1_0001: LFSR reset value. Must be nonzero.

Ports:
- `clk` in, 1: clock. All registers update on the rising edge.
- `rst` in, 1: asynchronous reset, active-high.
- `enable` in, 1: advance stimulus and count while high.
- `mode` in, 1: 0 = exhaustive counter, 1 = LFSR random. Sampled only while `rst` is high.
- `fault_inject` in, 1: when high, invert bit 0 of the adder sum before comparison.
- `a`, `b` out, N: current operands.
- `cin` out, 1: current carry-in.
- `s`, `cout` out, N / 1: carry-select adder result. Includes the injected fault.
- `s_ref`, `cout_ref` out, N / 1: reference result of `a+b+cin`.
- `prop` out, 1: group propagate, `&(a^b)`.
- `gen` out, 1: group generate, the carry-out of `a+b` with cin=0.
- `mismatch` out, 1: registered compare result for the previous cycle's vector.
- `err_count` out, 16: saturating mismatch count.
- `vec_count` out, 32: number of vectors compared.
- `done` out, 1: set when `vec_count` equals `NUM_VECTORS`.

## Operation
- **Stimulus register** V is 2N+1 bits, laid out as `{cin, a, b}`.
  - Counter mode: V increments by 1 each enabled cycle and wraps modulo 2^(2N+1).
  - LFSR mode: a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1. V equals the low 2N+1 bits of the LFSR state.
  - When N > 15, LFSR mode concatenates successive LFSR states to fill V.
- **Adder** is purely combinational.
  - Block 0 is a ripple-carry adder fed by `cin`.
  - Every other block computes two ripple sums, one with carry-in 0 and one with carry-in 1.
  - Each such block selects its sum and carry with a mux driven by the previous block's carry-out.
  - `cout` is the last block's selected carry.
- **Reference** is a behavioural N+1-bit addition: `{cout_ref, s_ref} = a + b + cin`.
- **Comparator**, on each rising edge with `enable` high and `done` low:
  - `mismatch` <= `({cout,s} != {cout_ref,s_ref})`.
  - `err_count` increments on mismatch and saturates at 16'hFFFF.
  - `vec_count` increments.
  - V advances.
- With `enable` low or `done` high: V and both counters hold, and `mismatch` clears to 0.
- `done` sets on the edge where `vec_count` becomes `NUM_VECTORS` and stays set until reset.

## Timing
- **Reset values** (`rst` high):
  - Counter mode: V = 0, so `a`=0, `b`=0, `cin`=0.
  - LFSR mode: V = low bits of `SEED`.
  - `mismatch`=0, `err_count`=0, `vec_count`=0, `done`=0.
- The adder and reference outputs are combinational from V and settle within the same cycle.
- Compare latency is 1 cycle: `mismatch` after edge k reflects the vector presented between edges k-1 and k.
- Asserting `rst` mid-run immediately clears all registers; no partial state survives.
- `fault_inject` is sampled combinationally and affects the compare at the next edge.
- The counter-mode wrap is seamless: the vector after all-ones is all-zeros.

## Test plan
- Reset in counter mode, then hold `enable`=0 → `a`=0, `b`=0, `cin`=0, `s`=0, `cout`=0, `prop`=0, `gen`=0. All counters stay 0.
- Counter mode, V forced to reach a=8'hFF, b=8'h01, cin=0 → `s`=8'h00, `cout`=1, `prop`=0, `gen`=1. Next edge gives `mismatch`=0.
- Vector a=8'h0F, b=8'hF0, cin=1 → `s`=8'h00, `cout`=1, `prop`=1, `gen`=0. This exercises carry propagating through both select blocks.
- `NUM_VECTORS`=131072, counter mode, `enable` held high → `done` rises exactly 131072 cycles after release of reset, with `err_count`=0 and `vec_count`=131072. V then holds.
- `fault_inject` high for 5 enabled cycles → `mismatch`=1 on each of the 5 following edges, and `err_count`=5.
- Assert `rst` after 1000 cycles in LFSR mode, then rerun → identical vector sequence starting from `SEED`, with counters restarting at 0.
